uart_txrx_param: RTL

UART_TXRX_PARAM -- requirements
Module: uart_txrx_param

---
 rtl/uart_txrx_param.sv | 349 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_txrx_param.sv
// Parameterised UART transmitter and receiver sharing one clock, with an
// optional internal loopback from tx_out to the receiver input.
module uart_txrx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clka,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_rdy,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_out,
  input  logic              rx_in,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_out,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_busy,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun,
  output logic [2:0]        tstate,
  output logic [2:0]        rstate
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_DLST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_SLST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    logic p;
    p = ^d;
    if (PARITY_ODD != 0) begin
      p = ~p;
    end else begin
      p = p;
    end
    return p;
  endfunction

  // ---------------- transmitter ----------------
  state_t              tstate_r, tstate_s;
  logic [CNT_W-1:0]    tcnt_r, tcnt_s;
  logic [IDX_W-1:0]    tidx_r, tidx_s;
  logic [DATA_W-1:0]   tdata_r, tdata_s;
  logic                tpar_r, tpar_s;
  logic                tx_out_r, tx_out_s;
  logic                tx_done_r, tx_done_s;
  logic                tx_busy_r;

  // TX next state; tx_out_s is the line level for the cycle after this edge
  always_comb begin
    tstate_s  = tstate_r;
    tcnt_s    = tcnt_r;
    tidx_s    = tidx_r;
    tdata_s   = tdata_r;
    tpar_s    = tpar_r;
    tx_out_s  = tx_out_r;
    tx_done_s = 1'b0;
    case (tstate_r)
      ST_IDLE: begin
        tcnt_s   = CNT_ZERO;
        tidx_s   = IDX_ZERO;
        tx_out_s = 1'b1;
        if (tx_rdy) begin
          tstate_s = ST_START;
          tdata_s  = tx_data;
          tpar_s   = parity_f(tx_data);
          tx_out_s = 1'b0;
        end else begin
          tstate_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tcnt_r == CNT_LAST) begin
          tcnt_s   = CNT_ZERO;
          tidx_s   = IDX_ZERO;
          tstate_s = ST_DATA;
          tx_out_s = tdata_r[0];
        end else begin
          tcnt_s = tcnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tcnt_r == CNT_LAST) begin
          tcnt_s  = CNT_ZERO;
          tdata_s = {1'b0, tdata_r[DATA_W-1:1]};
          if (tidx_r == IDX_DLST) begin
            tidx_s = IDX_ZERO;
            if (PARITY_EN != 0) begin
              tstate_s = ST_PARITY;
              tx_out_s = tpar_r;
            end else begin
              tstate_s = ST_STOP;
              tx_out_s = 1'b1;
            end
          end else begin
            tidx_s   = tidx_r + IDX_ONE;
            tx_out_s = tdata_r[1];
          end
        end else begin
          tcnt_s = tcnt_r + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (tcnt_r == CNT_LAST) begin
          tcnt_s   = CNT_ZERO;
          tidx_s   = IDX_ZERO;
          tstate_s = ST_STOP;
          tx_out_s = 1'b1;
        end else begin
          tcnt_s = tcnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        tx_out_s = 1'b1;
        // done is registered one cycle early so it lines up with the final stop cycle
        if ((tidx_r == IDX_SLST) && (tcnt_r == CNT_PRE)) begin
          tx_done_s = 1'b1;
        end else begin
          tx_done_s = 1'b0;
        end
        if (tcnt_r == CNT_LAST) begin
          tcnt_s = CNT_ZERO;
          if (tidx_r == IDX_SLST) begin
            tstate_s = ST_IDLE;
            tidx_s   = IDX_ZERO;
          end else begin
            tidx_s = tidx_r + IDX_ONE;
          end
        end else begin
          tcnt_s = tcnt_r + CNT_ONE;
        end
      end
      default: begin
        tstate_s = ST_IDLE;
        tx_out_s = 1'b1;
      end
    endcase
  end

  // TX state and output registers
  always_ff @(posedge clka) begin
    if (reset) begin
      tstate_r  <= ST_IDLE;
      tcnt_r    <= CNT_ZERO;
      tidx_r    <= IDX_ZERO;
      tdata_r   <= {DATA_W{1'b0}};
      tpar_r    <= 1'b0;
      tx_out_r  <= 1'b1;
      tx_done_r <= 1'b0;
      tx_busy_r <= 1'b0;
    end else begin
      tstate_r  <= tstate_s;
      tcnt_r    <= tcnt_s;
      tidx_r    <= tidx_s;
      tdata_r   <= tdata_s;
      tpar_r    <= tpar_s;
      tx_out_r  <= tx_out_s;
      tx_done_r <= tx_done_s;
      tx_busy_r <= (tstate_s != ST_IDLE);
    end
  end

  // ---------------- receiver ----------------
  logic                rx_mux_s;
  logic                rx_sync1_r, rx_sync2_r, rx_prev_r;
  state_t              rstate_r, rstate_s;
  logic [CNT_W-1:0]    rcnt_r, rcnt_s;
  logic [IDX_W-1:0]    ridx_r, ridx_s;
  logic [DATA_W-1:0]   rshift_r, rshift_s;
  logic                rpar_r, rpar_s;
  logic [DATA_W-1:0]   rx_out_r, rx_out_s;
  logic                rx_valid_r, rx_valid_s;
  logic                rx_perr_r, rx_perr_s;
  logic                rx_ferr_r, rx_ferr_s;
  logic                rx_ovr_r, rx_ovr_s;
  logic                rx_busy_r;

  // Receiver input source select
  always_comb begin
    if (loopback) begin
      rx_mux_s = tx_out_r;
    end else begin
      rx_mux_s = rx_in;
    end
  end

  // RX next state; start sampled mid-bit, later bits one full bit apart
  always_comb begin
    rstate_s   = rstate_r;
    rcnt_s     = rcnt_r;
    ridx_s     = ridx_r;
    rshift_s   = rshift_r;
    rpar_s     = rpar_r;
    rx_out_s   = rx_out_r;
    rx_perr_s  = rx_perr_r;
    rx_ferr_s  = rx_ferr_r;
    rx_valid_s = rx_valid_r;
    rx_ovr_s   = rx_ovr_r;
    if (rx_ack && rx_valid_r) begin
      rx_valid_s = 1'b0;
      rx_ovr_s   = 1'b0;
    end else begin
      rx_valid_s = rx_valid_r;
      rx_ovr_s   = rx_ovr_r;
    end
    case (rstate_r)
      ST_IDLE: begin
        rcnt_s = CNT_ZERO;
        ridx_s = IDX_ZERO;
        if (rx_prev_r && !rx_sync2_r) begin
          rstate_s = ST_START;
        end else begin
          rstate_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (rcnt_r == CNT_MID) begin
          rcnt_s = CNT_ZERO;
          if (rx_sync2_r) begin
            rstate_s = ST_IDLE;
          end else begin
            rstate_s = ST_DATA;
          end
        end else begin
          rcnt_s = rcnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rcnt_r == CNT_LAST) begin
          rcnt_s   = CNT_ZERO;
          rshift_s = {rx_sync2_r, rshift_r[DATA_W-1:1]};
          if (ridx_r == IDX_DLST) begin
            ridx_s = IDX_ZERO;
            if (PARITY_EN != 0) begin
              rstate_s = ST_PARITY;
            end else begin
              rstate_s = ST_STOP;
            end
          end else begin
            ridx_s = ridx_r + IDX_ONE;
          end
        end else begin
          rcnt_s = rcnt_r + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (rcnt_r == CNT_LAST) begin
          rcnt_s   = CNT_ZERO;
          rpar_s   = rx_sync2_r;
          rstate_s = ST_STOP;
        end else begin
          rcnt_s = rcnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (rcnt_r == CNT_LAST) begin
          rcnt_s     = CNT_ZERO;
          rstate_s   = ST_IDLE;
          rx_out_s   = rshift_r;
          rx_ferr_s  = ~rx_sync2_r;
          rx_valid_s = 1'b1;
          // an ack in the completing cycle consumes the old word, so no overrun
          rx_ovr_s   = rx_valid_r & ~rx_ack;
          if (PARITY_EN != 0) begin
            rx_perr_s = parity_f(rshift_r) ^ rpar_r;
          end else begin
            rx_perr_s = 1'b0;
          end
        end else begin
          rcnt_s = rcnt_r + CNT_ONE;
        end
      end
      default: begin
        rstate_s = ST_IDLE;
      end
    endcase
  end

  // RX synchroniser, state and output registers
  always_ff @(posedge clka) begin
    if (reset) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
      rstate_r   <= ST_IDLE;
      rcnt_r     <= CNT_ZERO;
      ridx_r     <= IDX_ZERO;
      rshift_r   <= {DATA_W{1'b0}};
      rpar_r     <= 1'b0;
      rx_out_r   <= {DATA_W{1'b0}};
      rx_valid_r <= 1'b0;
      rx_perr_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
      rx_ovr_r   <= 1'b0;
      rx_busy_r  <= 1'b0;
    end else begin
      rx_sync1_r <= rx_mux_s;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
      rstate_r   <= rstate_s;
      rcnt_r     <= rcnt_s;
      ridx_r     <= ridx_s;
      rshift_r   <= rshift_s;
      rpar_r     <= rpar_s;
      rx_out_r   <= rx_out_s;
      rx_valid_r <= rx_valid_s;
      rx_perr_r  <= rx_perr_s;
      rx_ferr_r  <= rx_ferr_s;
      rx_ovr_r   <= rx_ovr_s;
      rx_busy_r  <= (rstate_s != ST_IDLE);
    end
  end

  assign tx_busy       = tx_busy_r;
  assign tx_done       = tx_done_r;
  assign tx_out        = tx_out_r;
  assign tstate        = tstate_r;
  assign rx_out        = rx_out_r;
  assign rx_valid      = rx_valid_r;
  assign rx_busy       = rx_busy_r;
  assign rx_parity_err = rx_perr_r;
  assign rx_frame_err  = rx_ferr_r;
  assign rx_overrun    = rx_ovr_r;
  assign rstate        = rstate_r;

endmodule
